// File: rtl/l2_mem_requester.sv
// l2_mem_requester
//   Initiator between the L2 miss logic and main memory. Takes one miss
//   request at a time. If the victim is dirty, it writes the victim block back
//   first. It then reads the missed block and returns it to L2 with a one-cycle
//   resp_valid pulse. Strobes are held until memory raises mem_ready. A
//   one-cycle gap follows every strobe. A strobe held TIMEOUT_CYCLES cycles
//   without an answer aborts the request with resp_error.
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready        miss request handshake
//   req_addr                   missed word address (any word in the block)
//   req_wb, req_wb_addr,
//   req_wb_data                dirty-victim writeback request, address and block
//   resp_valid                 one-cycle pulse: fill done or aborted
//   resp_data, resp_error      fetched block (zero on error), timeout flag
//   mem_addr                   block-aligned address to memory
//   mem_wdata, mem_rdata       block data to and from memory
//   mem_read, mem_write        level strobes to memory
//   mem_ready                  memory finished the current strobe
module l2_mem_requester #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int BLOCK_SIZE     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [ADDR_WIDTH-1:0]                 req_addr,
  input  logic                                  req_wb,
  input  logic [ADDR_WIDTH-1:0]                 req_wb_addr,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] req_wb_data,
  output logic                                  resp_valid,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] resp_data,
  output logic                                  resp_error,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_wdata,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_rdata,
  output logic                                  mem_read,
  output logic                                  mem_write,
  input  logic                                  mem_ready
);

  localparam int BLOCK_BITS = $clog2(BLOCK_SIZE);
  localparam int TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << BLOCK_BITS;
  // The timer counts the strobe cycles that have already passed. When it
  // equals LAST, the current cycle is the TIMEOUT_CYCLES-th one.
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WB, WB_GAP, RD, RD_GAP} state_t;

  state_t                                state;
  state_t                                state_next;
  logic [TW-1:0]                         timer;
  logic [TW-1:0]                         timer_next;
  logic [ADDR_WIDTH-1:0]                 fill_addr;
  logic [ADDR_WIDTH-1:0]                 wb_addr;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] wb_data;
  logic                                  accept;
  logic                                  fill_done;
  logic                                  abort;

  // Strobes and handshakes are decoded from the state alone. On an
  // asynchronous reset, mem_read and mem_write therefore drop at the reset edge.
  always_comb begin
    state_next = state;
    timer_next = timer;
    accept     = 1'b0;
    fill_done  = 1'b0;
    abort      = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          timer_next = '0;
          state_next = req_wb ? WB : RD;
        end
      end
      WB: begin
        mem_write = 1'b1;
        mem_addr  = wb_addr;
        // mem_ready takes priority when it arrives on the expiry cycle.
        if (mem_ready) begin
          state_next = WB_GAP;
        end else begin
          timer_next = timer + TW'(1);
          if (timer == LAST) begin
            abort      = 1'b1;
            state_next = RD_GAP;   // a dead writeback also skips the fill
          end
        end
      end
      WB_GAP: begin
        // Memory may hold mem_ready one extra cycle. This gap ignores it.
        timer_next = '0;
        state_next = RD;
      end
      RD: begin
        mem_read = 1'b1;
        mem_addr = fill_addr;
        if (mem_ready) begin
          fill_done  = 1'b1;
          state_next = RD_GAP;
        end else begin
          timer_next = timer + TW'(1);
          if (timer == LAST) begin
            abort      = 1'b1;
            state_next = RD_GAP;
          end
        end
      end
      RD_GAP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_wdata = wb_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      fill_addr  <= '0;
      wb_addr    <= '0;
      wb_data    <= '0;
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      if (accept) begin
        fill_addr <= req_addr & ALIGN_MASK;
        wb_addr   <= req_wb_addr & ALIGN_MASK;
        wb_data   <= req_wb_data;
      end
      if (fill_done) begin
        resp_data  <= mem_rdata;
        resp_error <= 1'b0;
      end else if (abort) begin
        resp_data  <= '0;
        resp_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l2_mem_requester.sv
module tb_l2_mem_requester;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BS = 16;
  localparam int TO = 8;

  typedef logic [BS-1:0][DW-1:0] blk_t;

  typedef struct {
    logic [31:0] addr;
    logic        wb;
    logic [31:0] wb_addr;
    logic [31:0] wb_base;
    bit          mem_en;
    int          hold;
    logic [31:0] exp_rd;
    logic [31:0] exp_wr;
    logic        exp_err;
    int          exp_rd_cyc;
    int          exp_wr_cyc;
    int          exp_lat;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_wb;
  logic [AW-1:0] req_wb_addr;
  blk_t          req_wb_data;
  logic          resp_valid;
  blk_t          resp_data;
  logic          resp_error;
  logic [AW-1:0] mem_addr;
  blk_t          mem_wdata;
  blk_t          mem_rdata;
  logic          mem_read;
  logic          mem_write;
  logic          mem_ready;

  int total = 0;
  int bad   = 0;

  // Memory model settings.
  bit   mem_en      = 1'b1;
  int   mem_hold    = 1;
  logic force_ready = 1'b0;
  logic mem_ready_q;
  int   hold_left;

  l2_mem_requester #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wb(req_wb), .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word i of the block at address A holds A+i. Memory answers
  // one cycle after the strobe rises and holds mem_ready for mem_hold cycles.
  always_comb begin
    for (int i = 0; i < BS; i++) mem_rdata[i] = mem_addr + 32'(i);
  end
  assign mem_ready = mem_ready_q | force_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready_q <= 1'b0;
      hold_left   <= 0;
    end else if (hold_left > 0) begin
      mem_ready_q <= 1'b1;
      hold_left   <= hold_left - 1;
    end else if (mem_en && (mem_read || mem_write) && !mem_ready_q) begin
      mem_ready_q <= 1'b1;
      hold_left   <= mem_hold - 1;
    end else begin
      mem_ready_q <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [BS*DW-1:0] act, input logic [BS*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic blk_t ramp(input logic [31:0] base);
    blk_t b;
    for (int i = 0; i < BS; i++) b[i] = base + 32'(i);
    return b;
  endfunction

  function automatic vec_t mk(input logic [31:0] addr, input logic wb, input logic [31:0] wb_addr,
                              input logic [31:0] wb_base, input bit en, input int hold,
                              input logic [31:0] exp_rd, input logic [31:0] exp_wr, input logic err,
                              input int rd_cyc, input int wr_cyc, input int lat);
    vec_t v;
    v.addr = addr; v.wb = wb; v.wb_addr = wb_addr; v.wb_base = wb_base; v.mem_en = en;
    v.hold = hold; v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_err = err;
    v.exp_rd_cyc = rd_cyc; v.exp_wr_cyc = wr_cyc; v.exp_lat = lat;
    return v;
  endfunction

  // Drives one request and observes it until resp_valid. "lat" counts the
  // cycles after the accept edge: the cycle right after that edge is 1.
  task automatic run_vec(input int idx, input vec_t v);
    int   n = 0;
    bit   got = 1'b0;
    int   rd_cyc = 0, wr_cyc = 0, both = 0, busy_ready = 0;
    int   first_rd = -1, last_wr = -1;
    logic [31:0] rd_a = '0, wr_a = '0;
    blk_t wd_seen = '0;
    blk_t exp_blk;

    @(negedge clk);
    chk($sformatf("v%0d_ready_before", idx), 512'(req_ready), 512'(1));
    mem_en = v.mem_en; mem_hold = v.hold;
    req_valid = 1'b1; req_addr = v.addr; req_wb = v.wb; req_wb_addr = v.wb_addr;
    req_wb_data = ramp(v.wb_base);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = 32'hDEADBEEF; req_wb = ~v.wb;
    req_wb_addr = 32'hCAFE0000; req_wb_data = '1;

    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (mem_read) begin
        rd_cyc++; rd_a = mem_addr;
        if (first_rd < 0) first_rd = n;
      end
      if (mem_write) begin
        if (wr_cyc == 0) begin wr_a = mem_addr; wd_seen = mem_wdata; end
        wr_cyc++; last_wr = n;
      end
      if (mem_read && mem_write) both++;
      if (req_ready && !resp_valid) busy_ready++;
      if (resp_valid) got = 1'b1;
    end

    chk($sformatf("v%0d_resp_seen", idx), 512'(got), 512'(1));
    chk($sformatf("v%0d_latency", idx), 512'(n), 512'(v.exp_lat));
    chk($sformatf("v%0d_rd_cycles", idx), 512'(rd_cyc), 512'(v.exp_rd_cyc));
    chk($sformatf("v%0d_wr_cycles", idx), 512'(wr_cyc), 512'(v.exp_wr_cyc));
    chk($sformatf("v%0d_both_strobes", idx), 512'(both), 512'(0));
    chk($sformatf("v%0d_ready_while_busy", idx), 512'(busy_ready), 512'(0));
    if (v.exp_rd_cyc > 0) chk($sformatf("v%0d_rd_addr", idx), 512'(rd_a), 512'(v.exp_rd));
    if (v.exp_wr_cyc > 0) begin
      chk($sformatf("v%0d_wr_addr", idx), 512'(wr_a), 512'(v.exp_wr));
      chk($sformatf("v%0d_wr_data", idx), wd_seen, ramp(v.wb_base));
    end
    if (v.exp_rd_cyc > 0 && v.exp_wr_cyc > 0)
      chk($sformatf("v%0d_wb_gap", idx), 512'(first_rd - last_wr - 1), 512'(1));
    exp_blk = v.exp_err ? blk_t'('0) : ramp(v.exp_rd);
    chk($sformatf("v%0d_resp_data", idx), resp_data, exp_blk);
    chk($sformatf("v%0d_resp_error", idx), 512'(resp_error), 512'(v.exp_err));
    $display("req %0d addr=%h wb=%0b lat=%0d rd=%0d wr=%0d err=%0b", idx, v.addr, v.wb, n,
             rd_cyc, wr_cyc, resp_error);

    @(negedge clk);
    chk($sformatf("v%0d_single_pulse", idx), 512'(resp_valid), 512'(0));
    chk($sformatf("v%0d_ready_after", idx), 512'(req_ready), 512'(1));
  endtask

  vec_t vecs[7];

  initial begin
    int acc, rsp, both, cnt_resp, cnt_nrdy, cnt_rd;

    vecs[0] = mk(32'h123, 1'b0, 32'h0, 32'h0, 1'b1, 1, 32'h120, 32'h0, 1'b0, 2, 0, 3);
    vecs[1] = mk(32'h85, 1'b1, 32'h47, 32'hA0, 1'b1, 1, 32'h80, 32'h40, 1'b0, 2, 2, 6);
    vecs[2] = mk(32'h3FF, 1'b0, 32'h0, 32'h0, 1'b1, 2, 32'h3F0, 32'h0, 1'b0, 2, 0, 3);
    vecs[3] = mk(32'h200, 1'b0, 32'h0, 32'h0, 1'b0, 1, 32'h200, 32'h0, 1'b1, TO, 0, TO + 1);
    vecs[4] = mk(32'h300, 1'b1, 32'h510, 32'h11, 1'b0, 1, 32'h300, 32'h510, 1'b1, 0, TO, TO + 1);
    vecs[5] = mk(32'h555, 1'b0, 32'h0, 32'h0, 1'b1, 1, 32'h550, 32'h0, 1'b0, 2, 0, 3);
    vecs[6] = mk(32'hFFFFFFFF, 1'b1, 32'h1234, 32'h5000, 1'b1, 2, 32'hFFFFFFF0, 32'h1230, 1'b0, 2, 2, 6);

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wb = 1'b0;
    req_wb_addr = '0; req_wb_data = '0;
    #23;
    chk("rst_mem_read", 512'(mem_read), 512'(0));
    chk("rst_mem_write", 512'(mem_write), 512'(0));
    chk("rst_resp_valid", 512'(resp_valid), 512'(0));
    chk("rst_resp_error", 512'(resp_error), 512'(0));
    chk("rst_resp_data", resp_data, 512'(0));
    chk("rst_mem_addr", 512'(mem_addr), 512'(0));
    chk("rst_mem_wdata", mem_wdata, 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 512'(req_ready), 512'(1));

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // mem_ready asserted while IDLE must not start or finish anything.
    @(negedge clk);
    mem_en = 1'b1; mem_hold = 1; force_ready = 1'b1;
    cnt_resp = 0; cnt_nrdy = 0; cnt_rd = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid) cnt_resp++;
      if (!req_ready) cnt_nrdy++;
      if (mem_read || mem_write) cnt_rd++;
    end
    force_ready = 1'b0;
    chk("idle_ready_resp", 512'(cnt_resp), 512'(0));
    chk("idle_ready_notready", 512'(cnt_nrdy), 512'(0));
    chk("idle_ready_strobe", 512'(cnt_rd), 512'(0));
    $display("idle mem_ready: resp=%0d strobes=%0d", cnt_resp, cnt_rd);

    // Reset while a read is outstanding.
    @(negedge clk);
    mem_en = 1'b0;
    req_valid = 1'b1; req_addr = 32'h700; req_wb = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrd_read_before", 512'(mem_read), 512'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("midrd_read_dropped", 512'(mem_read), 512'(0));
    chk("midrd_write_low", 512'(mem_write), 512'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; mem_en = 1'b1;
    cnt_resp = 0; cnt_nrdy = 0; cnt_rd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (resp_valid) cnt_resp++;
      if (!req_ready) cnt_nrdy++;
      if (mem_read || mem_write) cnt_rd++;
    end
    chk("midrd_no_resp", 512'(cnt_resp), 512'(0));
    chk("midrd_ready", 512'(cnt_nrdy), 512'(0));
    chk("midrd_no_strobe", 512'(cnt_rd), 512'(0));
    $display("reset mid-read: resp=%0d not_ready=%0d", cnt_resp, cnt_nrdy);

    // Back-to-back requests with req_valid held high. Memory holds mem_ready
    // for 2 cycles. Each request takes IDLE, RD, RD, RD_GAP.
    mem_en = 1'b1; mem_hold = 2;
    acc = 0; rsp = 0; both = 0;
    @(negedge clk);
    req_valid = 1'b1; req_wb = 1'b0; req_addr = 32'h64B;
    for (int k = 0; k < 24; k++) begin
      if (req_ready) acc++;
      if (resp_valid) begin
        rsp++;
        $display("b2b resp at k=%0d err=%0b", k, resp_error);
      end
      if (mem_read && mem_write) both++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 512'(acc), 512'(6));
    chk("b2b_responses", 512'(rsp), 512'(6));
    chk("b2b_both_strobes", 512'(both), 512'(0));
    chk("b2b_resp_data", resp_data, ramp(32'h640));
    chk("b2b_resp_error", 512'(resp_error), 512'(0));
    @(negedge clk);
    chk("b2b_idle_ready", 512'(req_ready), 512'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
